// File: rtl/vlc_seq.sv
// Vehicle lighting controller: sequential turn sweep over LAMPS lamps per side,
// hazard flash and brake override. Lamps decode only from registered state.

module vlc_side #(
   parameter int LAMPS = 3,
   parameter int SW    = 2
) (
   input  logic             turning_i,
   input  logic             hazard_i,
   input  logic             brake_i,
   input  logic [SW-1:0]    step_i,
   output logic [LAMPS-1:0] lamp_o
);

   always_comb begin
      lamp_o = '0;
      if (hazard_i) begin
         // Hazard flashes on step parity and ignores brake
         lamp_o = step_i[0] ? '1 : '0;
      end else if (turning_i) begin
         for (int i = 0; i < LAMPS; i++) begin
            lamp_o[i] = (32'(step_i) > i);
         end
      end else begin
         lamp_o = brake_i ? '1 : '0;
      end
   end

endmodule

module vlc_seq #(
   parameter int LAMPS    = 3,
   parameter int TICK_DIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Turn_Left,
   input  logic             Turn_Right,
   input  logic             Emergency,
   input  logic             Brake,
   output logic [LAMPS-1:0] Left_Lamp,
   output logic [LAMPS-1:0] Right_Lamp,
   output logic [1:0]       Mode
);

   localparam int SW = $clog2(LAMPS + 1);
   localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LEFT   = 2'd1,
      RIGHT  = 2'd2,
      HAZARD = 2'd3
   } mode_e;

   mode_e            mode_q, mode_d, req;
   logic [SW-1:0]    step_q, step_d;
   logic [DW-1:0]    div_q, div_d;
   logic             brake_q;
   logic             tick;
   logic [1:0][LAMPS-1:0] lamp;

   always_comb begin
      req = IDLE;
      if (Emergency || (Turn_Left && Turn_Right)) req = HAZARD;
      else if (Turn_Left)                         req = LEFT;
      else if (Turn_Right)                        req = RIGHT;
   end

   // With TICK_DIV=1 div stays 0 and every cycle is a tick
   assign tick = (div_q == DW'(TICK_DIV - 1));

   always_comb begin
      mode_d = mode_q;
      step_d = step_q;
      div_d  = div_q;
      if (req != mode_q) begin
         mode_d = req;
         step_d = '0;
         div_d  = '0;
      end else if (mode_q != IDLE) begin
         div_d = tick ? '0 : div_q + 1'b1;
         if (tick) begin
            if (mode_q == HAZARD)
               step_d = (step_q == '0) ? SW'(1) : '0;
            else
               step_d = (step_q == SW'(LAMPS)) ? '0 : step_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q  <= IDLE;
         step_q  <= '0;
         div_q   <= '0;
         brake_q <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         step_q  <= step_d;
         div_q   <= div_d;
         brake_q <= Brake;
      end
   end

   // Side 0 is left (turns in LEFT), side 1 is right (turns in RIGHT)
   for (genvar s = 0; s < 2; s++) begin : g_side
      vlc_side #(.LAMPS(LAMPS), .SW(SW)) u_side (
         .turning_i (mode_q == mode_e'(s + 1)),
         .hazard_i  (mode_q == HAZARD),
         .brake_i   (brake_q),
         .step_i    (step_q),
         .lamp_o    (lamp[s])
      );
   end

   assign Left_Lamp  = lamp[0];
   assign Right_Lamp = lamp[1];
   assign Mode       = mode_q;

endmodule

// File: tb/tb_vlc_seq.sv
// Scoreboard bench for vlc_seq: two instances (3 lamps / div 4 and 5 lamps / div 1)
// share stimulus; a cycle-count reference model predicts each cycle's outputs.

module tb_vlc_seq;

   logic clk = 1'b0;
   logic rst_n, Turn_Left, Turn_Right, Emergency, Brake;
   logic [2:0] L0, R0;
   logic [4:0] L1, R1;
   logic [1:0] M0, M1;

   always #5 clk = ~clk;

   vlc_seq #(.LAMPS(3), .TICK_DIV(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .Turn_Left(Turn_Left), .Turn_Right(Turn_Right),
      .Emergency(Emergency), .Brake(Brake), .Left_Lamp(L0), .Right_Lamp(R0), .Mode(M0));

   vlc_seq #(.LAMPS(5), .TICK_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .Turn_Left(Turn_Left), .Turn_Right(Turn_Right),
      .Emergency(Emergency), .Brake(Brake), .Left_Lamp(L1), .Right_Lamp(R1), .Mode(M1));

   typedef struct {
      int mode;
      int l;
      int r;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int n_tests = 0;
   int n_fail  = 0;

   // Model: mode plus number of cycles spent in it since entry
   int m_mode[2];
   int m_n[2];
   int m_brk[2];
   int PL[2] = '{3, 5};
   int PT[2] = '{4, 1};

   task automatic cmp(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t model_out(input int k);
      exp_t e;
      int all, s, th, side_brk;
      all      = (1 << PL[k]) - 1;
      side_brk = m_brk[k] ? all : 0;
      e.mode   = m_mode[k];
      if (m_mode[k] == 3) begin
         s   = (m_n[k] / PT[k]) % 2;
         e.l = s ? all : 0;
         e.r = e.l;
      end else begin
         s  = (m_n[k] / PT[k]) % (PL[k] + 1);
         th = (1 << s) - 1;
         e.l = (m_mode[k] == 1) ? th : side_brk;
         e.r = (m_mode[k] == 2) ? th : side_brk;
      end
      return e;
   endfunction

   task automatic model_edge(input logic tl, tr, em, br, rn);
      int req;
      exp_t e;
      req = (em || (tl && tr)) ? 3 : tl ? 1 : tr ? 2 : 0;
      for (int k = 0; k < 2; k++) begin
         if (!rn) begin
            m_mode[k] = 0; m_n[k] = 0; m_brk[k] = 0;
         end else begin
            m_brk[k] = br;
            if (req != m_mode[k]) begin
               m_mode[k] = req; m_n[k] = 0;
            end else if (m_mode[k] != 0) begin
               m_n[k]++;
            end
         end
         e = model_out(k);
         if (k == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   task automatic cyc(input logic tl, tr, em, br, rn);
      @(negedge clk);
      Turn_Left = tl; Turn_Right = tr; Emergency = em; Brake = br; rst_n = rn;
      @(posedge clk);
      #1;
      model_edge(tl, tr, em, br, rn);
   endtask

   // Monitor: pop one expectation per instance each cycle an output is due
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            cmp("mode0", int'(M0), e.mode);
            cmp("left0", int'(L0), e.l);
            cmp("right0", int'(R0), e.r);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp("mode1", int'(M1), e.mode);
            cmp("left1", int'(L1), e.l);
            cmp("right1", int'(R1), e.r);
         end
      end
   end

   initial begin
      int th3[4] = '{0, 1, 3, 7};
      int th5[6] = '{0, 1, 3, 7, 15, 31};
      logic tl, tr, em, br, rn;
      int waited;
      rst_n = 1'b0; Turn_Left = 1'b1; Turn_Right = 1'b1; Emergency = 1'b1; Brake = 1'b1;

      // Reset with every input asserted, then release with inputs low
      repeat (3) begin
         cyc(1, 1, 1, 1, 0);
         cmp("rst_left0", int'(L0), 0);
         cmp("rst_mode0", int'(M0), 0);
      end
      repeat (2) cyc(0, 0, 0, 0, 1);
      cmp("idle_right1", int'(R1), 0);

      // Left sweep: cycle c counts outputs after the edge that took the request
      for (int c = 1; c <= 21; c++) begin
         cyc(1, 0, 0, 0, 1);
         cmp("sweep_left0", int'(L0), th3[((c - 1) / 4) % 4]);
         cmp("sweep_left1", int'(L1), th5[(c - 1) % 6]);
         cmp("sweep_right0", int'(R0), 0);
      end

      // Brake with right turn, then drop turn, then drop brake
      repeat (2) cyc(0, 0, 0, 0, 1);
      repeat (20) cyc(0, 1, 0, 1, 1);
      cmp("brk_left0", int'(L0), 7);
      repeat (2) cyc(0, 0, 0, 1, 1);
      cmp("brk_idle_r0", int'(R0), 7);
      cyc(0, 0, 0, 0, 1);
      cmp("brk_drop_l0", int'(L0), 0);

      // Hazard from both turns, with brake, then emergency alone
      repeat (12) cyc(1, 1, 0, 0, 1);
      repeat (8)  cyc(1, 1, 0, 1, 1);
      repeat (2)  cyc(0, 0, 0, 0, 1);
      repeat (8)  cyc(0, 0, 1, 0, 1);

      // Mid-sweep hazard then resume left from dark
      repeat (2) cyc(0, 0, 0, 0, 1);
      repeat (10) cyc(1, 0, 0, 0, 1);
      cmp("mid_left0", int'(L0), 3);
      cyc(1, 0, 1, 0, 1);
      cmp("mid_haz_mode0", int'(M0), 3);
      cmp("mid_haz_l0", int'(L0), 0);
      repeat (9) cyc(1, 0, 1, 0, 1);
      for (int c = 1; c <= 5; c++) begin
         cyc(1, 0, 0, 0, 1);
         cmp("resume_left0", int'(L0), (c <= 4) ? 0 : 1);
      end

      // Randomized segments: inputs mostly held so sequences get to run
      tl = 0; tr = 0; em = 0; br = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(7) == 0) tl = $urandom_range(1);
         if ($urandom_range(7) == 0) tr = $urandom_range(1);
         if ($urandom_range(15) == 0) em = $urandom_range(1);
         if ($urandom_range(5) == 0) br = $urandom_range(1);
         rn = ($urandom_range(99) != 0);
         cyc(tl, tr, em, br, rn);
      end

      // Reset mid-sweep
      repeat (3) cyc(1, 0, 0, 1, 1);
      cyc(1, 0, 0, 1, 0);
      cmp("rst_mid_left1", int'(L1), 0);
      cmp("rst_mid_right1", int'(R1), 0);
      cmp("rst_mid_mode1", int'(M1), 0);

      waited = 0;
      while ((q0.size() != 0 || q1.size() != 0) && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      if (q0.size() != 0 || q1.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d/%0d expectations left, required 0", q0.size(), q1.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
